nmc_ctrl: RTL and testbench

Sequencer for the near-memory-compute (aggregation + ReLU) stage. It accepts a job of N output tiles, each built from K partial-sum beats delivered by the CIM macro over a valid/ready handshake. It gates which cycles the aggregator accumulates and pulses relu_out_en on the last beat of each tile. It then issues a write-back strobe and address at the cycle the registered ReLU output is valid.

---
 rtl/nmc_ctrl.sv | 148 ++++++++++++++
 tb/tb_nmc_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/nmc_ctrl.sv
// nmc_ctrl: job sequencer for the near-memory-compute aggregation + ReLU stage.
// Counts K partial-sum beats per tile, gates the aggregator input, marks the
// final beat of each tile, then waits RELU_LAT cycles for the registered ReLU
// result before strobing a write-back to base+tile.
// Optional build macro: NMC_CTRL_PERF_EN adds busy/stall performance counters.
module nmc_ctrl #(
  parameter int K_W      = 8,
  parameter int TILE_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int RELU_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [K_W-1:0]    cfg_k,
  input  logic [TILE_W-1:0] cfg_tiles,
  input  logic [ADDR_W-1:0] cfg_wb_base,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              aggre_gate,
  output logic              relu_out_en,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr
`ifdef NMC_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_busy_cyc,
  output logic [31:0]       perf_stall_cyc
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  // Last FLUSH cycle index; RELU_LAT is limited to 1..15 so 4 bits suffice.
  localparam logic [3:0] LAT_LAST = 4'(RELU_LAT - 1);

  logic [1:0]        state;
  logic [K_W-1:0]    k_cnt;
  logic [K_W-1:0]    k_last;     // effective K minus one (cfg_k=0 behaves as 1)
  logic [TILE_W-1:0] tile_cnt;
  logic [TILE_W-1:0] tile_last;  // cfg_tiles minus one; unused when cfg_tiles=0
  logic [3:0]        lat_cnt;
  logic [ADDR_W-1:0] base;

  logic beat;
  logic flush_end;
  logic last_tile;

  // Output decode straight from registered state/counters so each event pulses once.
  always_comb begin
    busy        = (state != S_IDLE);
    in_ready    = (state == S_ACCUM);
    beat        = in_ready & in_valid;
    aggre_gate  = beat;
    relu_out_en = beat & (k_cnt == k_last);
    flush_end   = (state == S_FLUSH) & (lat_cnt == LAT_LAST);
    last_tile   = (tile_cnt == tile_last);
    wb_en       = flush_end;
    done        = (flush_end & last_tile) | (state == S_FIN);
    if (flush_end) begin
      wb_addr = base + ADDR_W'(tile_cnt);
    end else begin
      wb_addr = '0;
    end
  end

  // Sequencer state, beat/tile/latency counters and latched job configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k_cnt     <= '0;
      k_last    <= '0;
      tile_cnt  <= '0;
      tile_last <= '0;
      lat_cnt   <= 4'd0;
      base      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base      <= cfg_wb_base;
            k_last    <= (cfg_k == '0) ? '0 : (cfg_k - K_W'(1));
            tile_last <= cfg_tiles - TILE_W'(1);
            k_cnt     <= '0;
            tile_cnt  <= '0;
            lat_cnt   <= 4'd0;
            state     <= (cfg_tiles == '0) ? S_FIN : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (beat) begin
            if (k_cnt == k_last) begin
              k_cnt   <= '0;
              lat_cnt <= 4'd0;
              state   <= S_FLUSH;
            end else begin
              k_cnt <= k_cnt + K_W'(1);
            end
          end
        end
        S_FLUSH: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt <= 4'd0;
            if (last_tile) begin
              state <= S_IDLE;
            end else begin
              tile_cnt <= tile_cnt + TILE_W'(1);
              state    <= S_ACCUM;
            end
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef NMC_CTRL_PERF_EN
  // Saturating busy/stall counters, cleared when a job is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_cyc  <= 32'd0;
      perf_stall_cyc <= 32'd0;
    end else if ((state == S_IDLE) && start) begin
      perf_busy_cyc  <= 32'd0;
      perf_stall_cyc <= 32'd0;
    end else begin
      if (busy && (perf_busy_cyc != 32'hFFFF_FFFF)) begin
        perf_busy_cyc <= perf_busy_cyc + 32'd1;
      end
      if ((state == S_ACCUM) && !in_valid && (perf_stall_cyc != 32'hFFFF_FFFF)) begin
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nmc_ctrl.sv
// Testbench for nmc_ctrl: per job, a schedule of expected outputs is computed
// from the stage's rules (beats per tile, flush latency, address arithmetic)
// and compared cycle by cycle against the DUT under random in_valid traffic.
// With NMC_CTRL_PERF_EN defined the performance counters are also checked.
module tb_nmc_ctrl;

  localparam int K_W      = 8;
  localparam int TILE_W   = 8;
  localparam int ADDR_W   = 10;
  localparam int RELU_LAT = 2;
  localparam int MAXC     = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [K_W-1:0]    cfg_k;
  logic [TILE_W-1:0] cfg_tiles;
  logic [ADDR_W-1:0] cfg_wb_base;
  logic              busy, done, in_valid, in_ready, aggre_gate, relu_out_en, wb_en;
  logic [ADDR_W-1:0] wb_addr;
`ifdef NMC_CTRL_PERF_EN
  logic [31:0]       perf_busy_cyc, perf_stall_cyc;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  bit vin    [MAXC];
  bit e_busy [MAXC];
  bit e_ready[MAXC];
  bit e_gate [MAXC];
  bit e_relu [MAXC];
  bit e_wb   [MAXC];
  bit e_done [MAXC];
  int e_addr [MAXC];

  nmc_ctrl #(.K_W(K_W), .TILE_W(TILE_W), .ADDR_W(ADDR_W), .RELU_LAT(RELU_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_tiles(cfg_tiles),
    .cfg_wb_base(cfg_wb_base), .busy(busy), .done(done), .in_valid(in_valid),
    .in_ready(in_ready), .aggre_gate(aggre_gate), .relu_out_en(relu_out_en),
    .wb_en(wb_en), .wb_addr(wb_addr)
`ifdef NMC_CTRL_PERF_EN
    , .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {16'd0, busy, in_ready, aggre_gate, relu_out_en, wb_en, done, wb_addr};
  endfunction

  function automatic logic [31:0] exp_vec(input int c);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(e_addr[c]);
    return {16'd0, e_busy[c], e_ready[c], e_gate[c], e_relu[c], e_wb[c], e_done[c], a};
  endfunction

  // One job: cycle 0 presents start; cycles after it are predicted from the schedule.
  task automatic run_job(input int k, input int tiles, input int base, input int mode,
                         input bit do_abort, input int extra);
    int keff, c, endc, abort_at, relu_first, beats, pb, ps;
    bit aborted;
    for (int i = 0; i < MAXC; i++) begin
      e_busy[i] = 0; e_ready[i] = 0; e_gate[i] = 0; e_relu[i] = 0;
      e_wb[i] = 0; e_done[i] = 0; e_addr[i] = 0;
      case (mode)
        1:       vin[i] = 1'b1;
        2:       vin[i] = (i % 2 == 1);
        default: vin[i] = ($urandom_range(0, 3) != 0);
      endcase
    end
    keff = (k == 0) ? 1 : k;
    relu_first = -1;
    c = 1;
    if (tiles == 0) begin
      e_busy[1] = 1; e_done[1] = 1;
      c = 2;
    end else begin
      for (int t = 0; t < tiles; t++) begin
        beats = 0;
        while (beats < keff && c < MAXC - RELU_LAT - 4) begin
          e_busy[c] = 1; e_ready[c] = 1;
          if (vin[c]) begin
            e_gate[c] = 1;
            beats++;
            if (beats == keff) begin
              e_relu[c] = 1;
              if (relu_first < 0) relu_first = c;
            end
          end
          c++;
        end
        for (int j = 1; j <= RELU_LAT; j++) begin
          e_busy[c] = 1;
          if (j == RELU_LAT) begin
            e_wb[c]   = 1;
            e_addr[c] = (base + t) % (1 << ADDR_W);
            e_done[c] = (t == tiles - 1);
          end
          c++;
        end
      end
    end
    endc = c;
    abort_at = (do_abort && relu_first >= 0) ? relu_first + 1 : -1;
    pb = 0; ps = 0;
    for (int i = 0; i < endc; i++) begin
      if (e_busy[i]) pb++;
      if (e_ready[i] && !vin[i]) ps++;
    end
    aborted = 0;
    for (int cy = 0; cy < endc + extra; cy++) begin
      @(posedge clk); #1;
      rst = (cy == abort_at);
      if (cy == 0) begin
        start = 1'b1;
        cfg_k = K_W'(k); cfg_tiles = TILE_W'(tiles); cfg_wb_base = ADDR_W'(base);
      end else if (e_busy[cy] && !aborted) begin
        start = 1'($urandom_range(0, 1));
        cfg_k = K_W'($urandom); cfg_tiles = TILE_W'($urandom); cfg_wb_base = ADDR_W'($urandom);
      end else begin
        start = 1'b0;
      end
      in_valid = vin[cy];
      @(negedge clk);
      if (abort_at >= 0 && cy > abort_at) begin
        check($sformatf("k%0d t%0d post-reset cyc%0d", k, tiles, cy), obs_vec(), 32'd0);
      end else begin
        check($sformatf("k%0d t%0d cyc%0d", k, tiles, cy), obs_vec(), exp_vec(cy));
      end
      if (cy == abort_at) aborted = 1;
`ifdef NMC_CTRL_PERF_EN
      if (cy == endc - 1 && abort_at < 0) begin
        check("perf_busy", perf_busy_cyc, 32'(pb - 1));
        check("perf_stall", perf_stall_cyc, 32'(ps));
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b1;
    cfg_k = '0; cfg_tiles = '0; cfg_wb_base = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", obs_vec(), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("idle after reset", obs_vec(), 32'd0);

    run_job(4, 1, 'h010, 1, 1'b0, 1);   // basic single tile
    run_job(3, 3, 'h3FF, 1, 1'b0, 0);   // address wrap, back-to-back next job
    run_job(4, 1, 'h123, 2, 1'b0, 1);   // toggling in_valid
    run_job(0, 2, 'h050, 0, 1'b0, 0);   // cfg_k=0 behaves as 1
    run_job(5, 0, 'h200, 0, 1'b0, 1);   // zero tiles
    run_job(2, 2, 'h100, 1, 1'b1, 2);   // reset during first flush
    run_job(3, 2, 'h020, 0, 1'b0, 1);   // normal job after abort

    for (int n = 0; n < 25; n++) begin
      int rk, rt;
      rk = $urandom_range(0, 6);
      rt = $urandom_range(0, 4);
      run_job(rk, rt, $urandom_range(0, 1023), $urandom_range(0, 2),
              (rt > 0) && ($urandom_range(0, 5) == 0), $urandom_range(0, 2));
    end
    run_job(2, 1, 'h3FE, 0, 1'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
